orion_pll_supervisor: RTL and testbench

- Reset and lock supervisor for the system PLL. Runs on the 50 MHz reference clock.
- Drives the PLL reset input and consumes the PLL `locked` output.
- Releases a system reset only after lock has been held stable for a programmable time.
- On lock loss or lock timeout, re-resets the PLL automatically, keeps saturating statistics, and reports status to the rest of the design.

---
 rtl/orion_pll_supervisor.sv | 142 ++++++++++++++
 tb/tb_orion_pll_supervisor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/orion_pll_supervisor.sv
// Reset and lock supervisor for the system PLL: pulses the PLL reset, waits for a
// stable lock, releases the system reset and restarts the PLL whenever lock is lost.
module orion_pll_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 500000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             force_relock,
  input  logic             clear_stats,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] relock_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CYC_W-1:0] PLL_RST_LAST = CYC_W'(PLL_RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(STABLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_LAST     = CYC_W'(MAX_CYC - 1);
  localparam logic [CNT_W-1:0] STAT_MAX     = '1;

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CYC_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       sync_reg;
  logic             locked_s;
  logic             pll_rst_reg, sys_rst_reg, ready_reg;
  logic             timeout_hit, lock_lost;
  logic [1:0]       stat_inc;
  logic [CNT_W-1:0] stat_reg [2];

  assign locked_s = sync_reg[1];

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], pll_locked};
    end
  end

  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    lock_lost   = 1'b0;
    case (state_reg)
      S_RESET_PLL: begin
        if (cnt_reg == PLL_RST_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still counts as a lock.
        if (locked_s) begin
          state_next = S_STABLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next  = S_RESET_PLL;
          timeout_hit = 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s) state_next = S_WAIT_LOCK;
        else if (cnt_reg == STABLE_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        if (!locked_s) begin
          state_next = S_RESET_PLL;
          lock_lost  = 1'b1;
        end
      end
      default: state_next = S_RESET_PLL;
    endcase

    if (force_relock) begin
      state_next  = S_RESET_PLL;
      timeout_hit = 1'b0;
      lock_lost   = 1'b0;
    end

    // The counter only matters below CYC_LAST, so it parks there while in RUN.
    if (force_relock || (state_next != state_reg)) begin
      cnt_next = '0;
    end else if (cnt_reg == CYC_LAST) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + CYC_W'(1);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg   <= S_RESET_PLL;
      cnt_reg     <= '0;
      pll_rst_reg <= 1'b1;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pll_rst_reg <= (state_next == S_RESET_PLL);
      sys_rst_reg <= (state_next != S_RUN);
      ready_reg   <= (state_next == S_RUN);
    end
  end

  assign stat_inc = {timeout_hit, lock_lost};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stat
      always_ff @(posedge refclk) begin
        if (rst || clear_stats) begin
          stat_reg[gi] <= '0;
        end else if (stat_inc[gi] && (stat_reg[gi] != STAT_MAX)) begin
          stat_reg[gi] <= stat_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign pll_rst     = pll_rst_reg;
  assign sys_rst     = sys_rst_reg;
  assign ready       = ready_reg;
  assign state       = state_reg;
  assign relock_cnt  = stat_reg[0];
  assign timeout_cnt = stat_reg[1];

endmodule

// File: tb/tb_orion_pll_supervisor.sv
// Scoreboard bench for orion_pll_supervisor: directed scenarios followed by random
// lock behaviour, every cycle checked against a cycle-level reference model.
module tb_orion_pll_supervisor;

  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 32;
  localparam int STABLE_CYCLES  = 8;
  localparam int CNT_W          = 4;
  localparam int STAT_MAX       = (1 << CNT_W) - 1;

  localparam int M_RESET  = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STABLE = 2;
  localparam int M_RUN    = 3;

  logic             refclk = 1'b0;
  logic             rst = 1'b1;
  logic             pll_locked = 1'b0;
  logic             force_relock = 1'b0;
  logic             clear_stats = 1'b0;
  logic             pll_rst, sys_rst, ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] relock_cnt, timeout_cnt;

  orion_pll_supervisor #(
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .clear_stats (clear_stats),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .state       (state),
    .relock_cnt  (relock_cnt),
    .timeout_cnt (timeout_cnt)
  );

  always #10 refclk = ~refclk;

  typedef struct packed {
    logic [1:0]       st;
    logic             pr;
    logic             sr;
    logic             rd;
    logic [CNT_W-1:0] rc;
    logic [CNT_W-1:0] tc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: phase, time spent in phase, lock samples still in flight.
  int m_phase   = M_RESET;
  int m_dwell   = 0;
  int m_relocks = 0;
  int m_touts   = 0;
  bit m_lock_hist[$] = '{1'b0, 1'b0};

  function automatic void model_edge(input bit r, input bit lk, input bit fr, input bit cs);
    bit seen_lock;
    int nxt;
    bit add_tout, add_relock;
    if (r) begin
      m_phase = M_RESET; m_dwell = 0; m_relocks = 0; m_touts = 0;
      m_lock_hist = '{1'b0, 1'b0};
      return;
    end
    seen_lock  = m_lock_hist[0];
    nxt        = m_phase;
    add_tout   = 0;
    add_relock = 0;
    if (m_phase == M_RESET && m_dwell + 1 >= PLL_RST_CYCLES) nxt = M_WAIT;
    if (m_phase == M_WAIT) begin
      if (seen_lock) nxt = M_STABLE;
      else if (m_dwell + 1 >= LOCK_TIMEOUT) begin nxt = M_RESET; add_tout = 1; end
    end
    if (m_phase == M_STABLE) begin
      if (!seen_lock) nxt = M_WAIT;
      else if (m_dwell + 1 >= STABLE_CYCLES) nxt = M_RUN;
    end
    if (m_phase == M_RUN && !seen_lock) begin nxt = M_RESET; add_relock = 1; end
    if (fr) begin nxt = M_RESET; add_tout = 0; add_relock = 0; end
    if (cs) begin
      m_touts = 0; m_relocks = 0;
    end else begin
      if (add_tout) m_touts = (m_touts < STAT_MAX) ? m_touts + 1 : STAT_MAX;
      if (add_relock) m_relocks = (m_relocks < STAT_MAX) ? m_relocks + 1 : STAT_MAX;
    end
    m_dwell = (fr || nxt != m_phase) ? 0 : m_dwell + 1;
    m_phase = nxt;
    void'(m_lock_hist.pop_front());
    m_lock_hist.push_back(lk);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st = 2'(m_phase);
    e.pr = (m_phase == M_RESET);
    e.sr = (m_phase != M_RUN);
    e.rd = (m_phase == M_RUN);
    e.rc = CNT_W'(m_relocks);
    e.tc = CNT_W'(m_touts);
    return e;
  endfunction

  task automatic step(input bit r, input bit lk, input bit fr, input bit cs);
    rst = r; pll_locked = lk; force_relock = fr; clear_stats = cs;
    @(posedge refclk);
    model_edge(r, lk, fr, cs);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge refclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{st: state, pr: pll_rst, sr: sys_rst, rd: ready, rc: relock_cnt, tc: timeout_cnt};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL outputs @%0t: got st=%0d pll_rst=%0b sys_rst=%0b ready=%0b relock=%0d tout=%0d, expected st=%0d pll_rst=%0b sys_rst=%0b ready=%0b relock=%0d tout=%0d",
                 $time, a.st, a.pr, a.sr, a.rd, a.rc, a.tc, e.st, e.pr, e.sr, e.rd, e.rc, e.tc);
      end
    end
  end

  task automatic hold_until_state(input int target, input bit lk);
    int n = 0;
    while (state != 2'(target) && n < 200) begin
      step(0, lk, 0, 0);
      n++;
    end
    chk($sformatf("reach_state_%0d", target), int'(state), target);
  endtask

  initial begin
    int lat;
    bit lk;
    repeat (3) step(1, 0, 0, 0);
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_ready", int'(ready), 0);

    // PLL reset pulse and lock latency.
    repeat (PLL_RST_CYCLES) step(0, 0, 0, 0);
    chk("wait_lock_after_pulse", int'(state), M_WAIT);
    chk("pll_rst_low_after_pulse", int'(pll_rst), 0);
    repeat (5) step(0, 0, 0, 0);
    lat = 0;
    do begin
      step(0, 1, 0, 0);
      lat++;
    end while (!ready && lat < 40);
    chk("lock_to_ready_edges", lat, 2 + 1 + STABLE_CYCLES);
    chk("run_sys_rst", int'(sys_rst), 0);

    // Lock glitch inside STABLE.
    step(0, 1, 1, 0);
    hold_until_state(M_STABLE, 1);
    repeat (5) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (30) step(0, 1, 0, 0);

    // Continuous timeouts until saturation.
    repeat (16 * (LOCK_TIMEOUT + PLL_RST_CYCLES) + 40) step(0, 0, 0, 0);
    chk("timeout_saturated", int'(timeout_cnt), STAT_MAX);

    // Lock loss in RUN, then clear racing an increment.
    step(0, 1, 0, 1);
    hold_until_state(M_RUN, 1);
    repeat (3) step(0, 0, 0, 0);
    chk("relock_cnt_after_drop", int'(relock_cnt), 1);
    chk("pll_rst_after_drop", int'(pll_rst), 1);
    chk("sys_rst_after_drop", int'(sys_rst), 1);
    hold_until_state(M_RUN, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("clear_beats_increment", int'(relock_cnt), 0);

    // force_relock in RUN, then rst in STABLE.
    hold_until_state(M_RUN, 1);
    step(0, 1, 1, 0);
    chk("force_relock_state", int'(state), M_RESET);
    chk("force_relock_no_stat", int'(relock_cnt), 0);
    hold_until_state(M_STABLE, 1);
    step(1, 1, 0, 0);
    chk("mid_stable_rst_state", int'(state), M_RESET);
    chk("mid_stable_rst_sys_rst", int'(sys_rst), 1);
    chk("mid_stable_rst_tout", int'(timeout_cnt), 0);

    // Random lock behaviour with sporadic control pulses.
    for (int seg = 0; seg < 120; seg++) begin
      int mode = $urandom_range(0, 3);
      int len  = (mode == 1) ? $urandom_range(5, 80) : $urandom_range(5, 40);
      int glitch_at = $urandom_range(0, len - 1);
      for (int c = 0; c < len; c++) begin
        case (mode)
          0: lk = 1;
          1: lk = 0;
          2: lk = $urandom_range(0, 1);
          default: lk = (c != glitch_at);
        endcase
        step($urandom_range(0, 499) == 0, lk, $urandom_range(0, 199) == 0,
             $urandom_range(0, 149) == 0);
      end
    end

    repeat (2) @(posedge refclk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
